// File: rtl/packet_header_deparser.sv
// Transmit-side header deparser: replaces the first HDR_BEATS beats of a buffered packet with PHV data.
// Optional DEPARSER_DROP_EN adds a phv_drop input that discards the paired packet.
module packet_header_deparser #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int HDR_BEATS            = 2,
   parameter int PHV_WIDTH            = 512
) (
   input  logic                                 axis_clk,
   input  logic                                 areset,
   input  logic [PHV_WIDTH-1:0]                 phv_in,
   input  logic                                 phv_valid,
   output logic                                 phv_ready,
`ifdef DEPARSER_DROP_EN
   input  logic                                 phv_drop,
`endif
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                                 s_axis_tvalid,
   input  logic                                 s_axis_tlast,
   output logic                                 s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                                 m_axis_tvalid,
   output logic                                 m_axis_tlast,
   input  logic                                 m_axis_tready
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int TU = C_S_AXIS_TUSER_WIDTH;
   localparam int BW = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam logic [BW-1:0] LAST_HDR = BW'(HDR_BEATS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_BODY = 2'd2;
`ifdef DEPARSER_DROP_EN
   localparam logic [1:0] ST_DROP = 2'd3;
`endif

   logic [1:0]           state_q, state_d;
   logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
   logic [PHV_WIDTH-1:0] phv_reg_q, phv_reg_d;
   logic [DW-1:0]        m_tdata_q, m_tdata_d;
   logic [KW-1:0]        m_tkeep_q, m_tkeep_d;
   logic [TU-1:0]        m_tuser_q, m_tuser_d;
   logic                 m_tvalid_q, m_tvalid_d;
   logic                 m_tlast_q, m_tlast_d;

   logic                 adv;
   logic                 s_hs;
   logic [DW-1:0]        hdr_beat;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      phv_reg_d  = phv_reg_q;
      m_tdata_d  = m_tdata_q;
      m_tkeep_d  = m_tkeep_q;
      m_tuser_d  = m_tuser_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;

      adv           = !m_tvalid_q || m_axis_tready;
      phv_ready     = !areset && (state_q == ST_IDLE);
      s_axis_tready = 1'b0;
      if (state_q == ST_HDR || state_q == ST_BODY) begin
         s_axis_tready = !areset && adv;
      end
`ifdef DEPARSER_DROP_EN
      // Dropped packets are drained regardless of downstream backpressure.
      if (state_q == ST_DROP) begin
         s_axis_tready = !areset;
      end
`endif
      s_hs = s_axis_tvalid && s_axis_tready;

      hdr_beat = '0;
      for (int unsigned k = 0; k < HDR_BEATS; k++) begin
         if (beat_cnt_q == BW'(k)) begin
            hdr_beat = phv_reg_q[k*DW +: DW];
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (phv_valid && phv_ready) begin
               phv_reg_d  = phv_in;
               beat_cnt_d = '0;
`ifdef DEPARSER_DROP_EN
               state_d    = phv_drop ? ST_DROP : ST_HDR;
`else
               state_d    = ST_HDR;
`endif
            end
         end
         ST_HDR: begin
            if (s_hs) begin
               if (s_axis_tlast) begin
                  state_d = ST_IDLE;
               end else if (beat_cnt_q == LAST_HDR) begin
                  state_d = ST_BODY;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            if (s_hs && s_axis_tlast) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      if (s_hs && (state_q == ST_HDR || state_q == ST_BODY)) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = (state_q == ST_HDR) ? hdr_beat : s_axis_tdata;
         m_tkeep_d  = s_axis_tkeep;
         m_tuser_d  = s_axis_tuser;
         m_tlast_d  = s_axis_tlast;
      end else if (adv) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         phv_reg_q  <= '0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tuser_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         phv_reg_q  <= phv_reg_d;
         m_tdata_q  <= m_tdata_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tuser_q  <= m_tuser_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tuser  = m_tuser_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;

endmodule

// File: tb/tb_packet_header_deparser.sv
// Self-checking bench for packet_header_deparser; drop scenario runs when DEPARSER_DROP_EN is defined.
module tb_packet_header_deparser;

   localparam int DW = 256;
   localparam int KW = 32;
   localparam int TU = 128;
   localparam int HB = 2;
   localparam int PW = 512;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [TU-1:0] user;
      logic          last;
   } beat_t;

   typedef struct {
      logic [PW-1:0] phv;
      logic          drop;
   } phv_t;

   logic          clk = 1'b0;
   logic          areset;
   logic [PW-1:0] phv_in;
   logic          phv_valid;
   logic          phv_ready;
`ifdef DEPARSER_DROP_EN
   logic          phv_drop;
`endif
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic [TU-1:0] s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [TU-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;

   packet_header_deparser #(
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_TUSER_WIDTH(TU),
      .HDR_BEATS           (HB),
      .PHV_WIDTH           (PW)
   ) dut (
      .axis_clk     (clk),
      .areset       (areset),
      .phv_in       (phv_in),
      .phv_valid    (phv_valid),
      .phv_ready    (phv_ready),
`ifdef DEPARSER_DROP_EN
      .phv_drop     (phv_drop),
`endif
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tkeep (s_axis_tkeep),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tready(m_axis_tready)
   );

   always #5 clk = ~clk;

   beat_t beat_q[$];
   beat_t exp_q[$];
   beat_t obs_q[$];
   phv_t  phv_q[$];
   int    accept_cyc_q[$];
   int    tlast_cyc_q[$];
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   logic  s_hs_f = 1'b0;
   logic  p_hs_f = 1'b0;
   int    tr_mode = 0;
   bit    s_gap_en = 1'b0;

   function automatic logic [DW-1:0] rand_dw();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Reference: header beats come from the PHV slices, the rest pass through; dropped packets emit nothing.
   task automatic add_pkt(input logic [PW-1:0] phv, input int n, input logic drop, input logic [KW-1:0] last_keep);
      beat_t b;
      phv_t  p;
      p.phv  = phv;
      p.drop = drop;
      phv_q.push_back(p);
      for (int i = 0; i < n; i++) begin
         b.data = rand_dw();
         b.keep = (i == n-1) ? last_keep : '1;
         b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
         b.last = (i == n-1);
         beat_q.push_back(b);
         if (!drop) begin
            if (i < HB) b.data = phv[i*DW +: DW];
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic clear_queues();
      exp_q.delete();
      obs_q.delete();
      accept_cyc_q.delete();
      tlast_cyc_q.delete();
   endtask

   task automatic drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (phv_q.size() == 0 && beat_q.size() == 0 && obs_q.size() >= exp_q.size() && !m_axis_tvalid) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      beat_t o;
      forever begin
         @(negedge clk);
         s_hs_f = s_axis_tvalid & s_axis_tready;
         p_hs_f = phv_valid & phv_ready;
         if (m_axis_tvalid && m_axis_tready) begin
            o.data = m_axis_tdata;
            o.keep = m_axis_tkeep;
            o.user = m_axis_tuser;
            o.last = m_axis_tlast;
            obs_q.push_back(o);
         end
         if (p_hs_f) accept_cyc_q.push_back(cyc);
         if (s_hs_f && s_axis_tlast) tlast_cyc_q.push_back(cyc);
      end
   end

   initial begin
      phv_valid = 1'b0;
      phv_in    = '0;
`ifdef DEPARSER_DROP_EN
      phv_drop  = 1'b0;
`endif
      forever begin
         @(posedge clk);
         #1;
         if (p_hs_f) void'(phv_q.pop_front());
         if (phv_q.size() > 0) begin
            phv_valid = 1'b1;
            phv_in    = phv_q[0].phv;
`ifdef DEPARSER_DROP_EN
            phv_drop  = phv_q[0].drop;
`endif
         end else begin
            phv_valid = 1'b0;
         end
      end
   end

   initial begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      s_axis_tlast  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (s_hs_f) void'(beat_q.pop_front());
         if (!(s_axis_tvalid && !s_hs_f)) begin
            if (beat_q.size() > 0 && (!s_gap_en || $urandom_range(0, 3) != 0)) begin
               s_axis_tvalid = 1'b1;
               s_axis_tdata  = beat_q[0].data;
               s_axis_tkeep  = beat_q[0].keep;
               s_axis_tuser  = beat_q[0].user;
               s_axis_tlast  = beat_q[0].last;
            end else begin
               s_axis_tvalid = 1'b0;
            end
         end
      end
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (tr_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (phv_ready !== 1'b0) begin n_fail++; $display("FAIL reset_phv_ready got %b want 0", phv_ready); end
      n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready got %b want 0", s_axis_tready); end
      n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got %b want 0", m_axis_tvalid); end
      n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast got %b want 0", m_axis_tlast); end
      n_checks++;
      if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser} !== '0) begin
         n_fail++; $display("FAIL reset_m_payload got data=%h keep=%h want 0", m_axis_tdata, m_axis_tkeep);
      end
      @(posedge clk);
      #1 areset = 1'b0;
      @(negedge clk);
      n_checks++; if (phv_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_phv_ready got %b want 1", phv_ready); end
   endtask

   task automatic test_basic();
      int    first_s = -1, first_m = -1;
      bit    ok;
      beat_t e, o;
      clear_queues();
      tr_mode = 0;
      add_pkt({rand_dw(), rand_dw()}, 4, 1'b0, '1);
      for (int i = 0; i < 60 && first_m < 0; i++) begin
         @(negedge clk);
         if (first_s < 0 && s_axis_tvalid && s_axis_tready) first_s = cyc;
         if (first_m < 0 && m_axis_tvalid) first_m = cyc;
      end
      n_checks++;
      if (first_s < 0 || first_m != first_s + 1) begin
         n_fail++; $display("FAIL basic_latency got first_m=%0d first_s=%0d want first_m=first_s+1", first_m, first_s);
      end
      drain(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_drain got timeout want drained"); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if ({o.data, o.keep, o.user, o.last} !== {e.data, e.keep, e.user, e.last}) begin
            n_fail++; $display("FAIL basic_beat %0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b", i, o.data, o.keep, o.last, e.data, e.keep, e.last);
         end
      end
   endtask

   task automatic test_single_beat();
      bit    ok, seen = 1'b0;
      beat_t e, o;
      clear_queues();
      tr_mode = 0;
      add_pkt({rand_dw(), rand_dw()}, 1, 1'b0, 32'h0000_FFFF);
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (s_axis_tvalid && s_axis_tready && s_axis_tlast) seen = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if (!seen || phv_ready !== 1'b1) begin n_fail++; $display("FAIL single_idle_after got seen=%b phv_ready=%b want 1,1", seen, phv_ready); end
      drain(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_drain got timeout want drained"); end
      n_checks++;
      if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
      if (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if ({o.data, o.keep, o.user, o.last} !== {e.data, e.keep, e.user, e.last}) begin
            n_fail++; $display("FAIL single_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", o.data, o.keep, o.last, e.data, e.keep, e.last);
         end
      end
   endtask

   task automatic test_stall();
      bit    held_v = 1'b0, done = 1'b0, ok;
      beat_t held, e, o;
      clear_queues();
      tr_mode = 1;
      add_pkt({rand_dw(), rand_dw()}, 6, 1'b0, '1);
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (held_v) begin
            n_checks++;
            if (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== {held.data, held.keep, held.user, held.last}) begin
               n_fail++; $display("FAIL stall_hold got valid=%b data=%h want valid=1 data=%h", m_axis_tvalid, m_axis_tdata, held.data);
            end
         end
         held_v = m_axis_tvalid && !m_axis_tready;
         if (held_v) begin
            held.data = m_axis_tdata; held.keep = m_axis_tkeep;
            held.user = m_axis_tuser; held.last = m_axis_tlast;
            n_checks++;
            if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL stall_s_tready got %b want 0", s_axis_tready); end
         end
         done = beat_q.size() == 0 && obs_q.size() >= exp_q.size() && !m_axis_tvalid;
      end
      tr_mode = 0;
      drain(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_drain got timeout want drained"); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if ({o.data, o.keep, o.user, o.last} !== {e.data, e.keep, e.user, e.last}) begin
            n_fail++; $display("FAIL stall_beat %0d got data=%h last=%b want data=%h last=%b", i, o.data, o.last, e.data, e.last);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit    ok;
      beat_t e, o;
      clear_queues();
      tr_mode = 0;
      add_pkt({rand_dw(), rand_dw()}, 3, 1'b0, '1);
      add_pkt({rand_dw(), rand_dw()}, 3, 1'b0, 32'h00FF_FFFF);
      drain(150, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_drain got timeout want drained"); end
      n_checks++;
      if (accept_cyc_q.size() != 2 || tlast_cyc_q.size() != 2 || accept_cyc_q[1] != tlast_cyc_q[0] + 1) begin
         n_fail++;
         $display("FAIL b2b_accept_timing got accepts=%0d tlasts=%0d second_accept=%0d want first_tlast+1=%0d",
                  accept_cyc_q.size(), tlast_cyc_q.size(),
                  (accept_cyc_q.size() > 1) ? accept_cyc_q[1] : -1,
                  (tlast_cyc_q.size() > 0) ? tlast_cyc_q[0] + 1 : -1);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if ({o.data, o.keep, o.user, o.last} !== {e.data, e.keep, e.user, e.last}) begin
            n_fail++; $display("FAIL b2b_beat %0d got data=%h last=%b want data=%h last=%b", i, o.data, o.last, e.data, e.last);
         end
      end
   endtask

   task automatic test_random();
      bit    ok;
      beat_t e, o;
      clear_queues();
      tr_mode  = 2;
      s_gap_en = 1'b1;
      for (int p = 0; p < 10; p++) begin
         add_pkt({rand_dw(), rand_dw()}, $urandom_range(1, 6), 1'b0, $urandom() | 32'h1);
      end
      drain(3000, ok);
      tr_mode  = 0;
      s_gap_en = 1'b0;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL random_drain got timeout want drained"); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if ({o.data, o.keep, o.user, o.last} !== {e.data, e.keep, e.user, e.last}) begin
            n_fail++; $display("FAIL random_beat %0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b", i, o.data, o.keep, o.last, e.data, e.keep, e.last);
         end
      end
   endtask

`ifdef DEPARSER_DROP_EN
   task automatic test_drop();
      int    consumed = 0;
      bit    seen = 1'b0, ok;
      beat_t e, o;
      clear_queues();
      tr_mode = 0;
      add_pkt({rand_dw(), rand_dw()}, 3, 1'b1, '1);
      add_pkt({rand_dw(), rand_dw()}, 3, 1'b0, '1);
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         n_checks++;
         if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL drop_m_tvalid got %b want 0", m_axis_tvalid); end
         if (s_axis_tvalid && s_axis_tready) begin
            consumed++;
            if (s_axis_tlast) seen = 1'b1;
         end
      end
      n_checks++;
      if (consumed != 3) begin n_fail++; $display("FAIL drop_consumed got %0d want 3", consumed); end
      drain(150, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_drain got timeout want drained"); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if ({o.data, o.keep, o.user, o.last} !== {e.data, e.keep, e.user, e.last}) begin
            n_fail++; $display("FAIL drop_next_beat %0d got data=%h last=%b want data=%h last=%b", i, o.data, o.last, e.data, e.last);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_single_beat();
      test_stall();
      test_back_to_back();
      test_random();
`ifdef DEPARSER_DROP_EN
      test_drop();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
